// File: rtl/hcsr04_ranger_if.sv
// Signal bundle between the HC-SR04 ranger and the sensor/consumer side.
// master = the ranger itself; slave = whoever drives enable/echo and reads results.
interface hcsr04_ranger_if;
  logic        enable;
  logic        echo;
  logic        trig;
  logic [15:0] distance;
  logic        valid;
  logic        timeout;
  logic        busy;

  modport master (
    input  enable,
    input  echo,
    output trig,
    output distance,
    output valid,
    output timeout,
    output busy
  );

  modport slave (
    output enable,
    output echo,
    input  trig,
    input  distance,
    input  valid,
    input  timeout,
    input  busy
  );
endinterface

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranger: trigger pulse, echo timing on a 1 us tick, floor
// conversion to cm by repeated counting, one registered result per trigger.
module hcsr04_ranger #(
  parameter int unsigned CYC_PER_US      = 12,
  parameter int unsigned TRIG_US         = 10,
  parameter int unsigned US_PER_CM       = 58,
  parameter int unsigned RISE_TIMEOUT_US = 30000,
  parameter int unsigned MAX_ECHO_US     = 25000,
  parameter int unsigned PERIOD_US       = 60000
) (
  input  logic              clk,
  input  logic              rst,
  hcsr04_ranger_if.master   bus
);

  localparam int unsigned PRE_W = 4;
  localparam int unsigned US_W  = 17;
  localparam int unsigned CM_W  = 16;

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CYC_PER_US - 1);
  localparam logic [US_W-1:0]  TRIG_LEN   = US_W'(TRIG_US);
  localparam logic [US_W-1:0]  RISE_LEN   = US_W'(RISE_TIMEOUT_US);
  localparam logic [US_W-1:0]  ECHO_LEN   = US_W'(MAX_ECHO_US);
  localparam logic [US_W-1:0]  PERIOD_LEN = US_W'(PERIOD_US);
  localparam logic [US_W-1:0]  FRAC_LAST  = US_W'(US_PER_CM - 1);
  localparam logic [CM_W-1:0]  CM_SAT     = 16'hFFFE;
  localparam logic [CM_W-1:0]  NO_TARGET  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              echo_prev_q, echo_prev_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [US_W-1:0]   us_q, us_d;
  logic [US_W-1:0]   frac_q, frac_d;
  logic [CM_W-1:0]   cm_q, cm_d;
  logic [PRE_W-1:0]  per_pre_q, per_pre_d;
  logic [US_W-1:0]   per_q, per_d;
  logic [CM_W-1:0]   dist_q, dist_d;
  logic              to_q, to_d;
  logic              valid_q, valid_d;

  logic              echo_s;
  logic              rise;
  logic              fall;
  logic              tick;
  logic              per_tick;
  logic              post;
  logic              post_to;
  logic              frac_wrap;
  logic [US_W-1:0]   us_next;
  logic [CM_W-1:0]   cm_next;

  assign echo_s   = sync2_q;
  assign rise     = echo_s & ~echo_prev_q;
  assign fall     = ~echo_s & echo_prev_q;
  assign tick     = (pre_q == PRE_LAST);
  assign per_tick = (per_pre_q == PRE_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    sync1_d     = bus.echo;
    sync2_d     = sync1_q;
    echo_prev_d = sync2_q;
    state_d     = state_q;
    post        = 1'b0;
    post_to     = 1'b0;
    us_d        = us_q;
    frac_d      = frac_q;
    cm_d        = cm_q;
    us_next     = tick ? us_q + 1'b1 : us_q;
    frac_wrap   = tick && (frac_q == FRAC_LAST);
    cm_next     = (frac_wrap && (cm_q != CM_SAT)) ? cm_q + 1'b1 : cm_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_TRIG;
      end
      S_TRIG: begin
        us_d = us_next;
        if (tick && (us_next == TRIG_LEN)) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        us_d = us_next;
        if (rise) begin
          state_d = S_MEASURE;
        end else if (tick && (us_next == RISE_LEN)) begin
          post    = 1'b1;
          post_to = 1'b1;
          state_d = S_HOLDOFF;
        end
      end
      S_MEASURE: begin
        us_d   = us_next;
        cm_d   = cm_next;
        frac_d = frac_wrap ? '0 : (tick ? frac_q + 1'b1 : frac_q);
        // The fall-cycle tick is folded into the posted distance so a width of exactly N*US_PER_CM reads N.
        if (fall) begin
          post    = 1'b1;
          state_d = S_HOLDOFF;
        end else if (tick && (us_next == ECHO_LEN)) begin
          post    = 1'b1;
          post_to = 1'b1;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if ((per_q >= PERIOD_LEN) && !echo_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      pre_d  = '0;
      us_d   = '0;
      frac_d = '0;
      cm_d   = '0;
    end else begin
      pre_d  = tick ? '0 : pre_q + 1'b1;
    end

    // The period timer has its own prescaler so state-entry restarts never skew the trigger spacing.
    if ((state_q == S_IDLE) && (state_d == S_TRIG)) begin
      per_pre_d = '0;
      per_d     = '0;
    end else begin
      per_pre_d = per_tick ? '0 : per_pre_q + 1'b1;
      per_d     = (per_tick && (per_q < PERIOD_LEN)) ? per_q + 1'b1 : per_q;
    end

    valid_d = post;
    dist_d  = post ? (post_to ? NO_TARGET : cm_next) : dist_q;
    to_d    = post ? post_to : to_q;
  end

  // NOTE: state flops take non-blocking assignments so every register samples its pre-edge _d value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      echo_prev_q <= 1'b0;
      pre_q       <= '0;
      us_q        <= '0;
      frac_q      <= '0;
      cm_q        <= '0;
      per_pre_q   <= '0;
      per_q       <= '0;
      dist_q      <= '0;
      to_q        <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      echo_prev_q <= echo_prev_d;
      pre_q       <= pre_d;
      us_q        <= us_d;
      frac_q      <= frac_d;
      cm_q        <= cm_d;
      per_pre_q   <= per_pre_d;
      per_q       <= per_d;
      dist_q      <= dist_d;
      to_q        <= to_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.trig     = (state_q == S_TRIG);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.distance = dist_q;
  assign bus.timeout  = to_q;
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger with shortened timeouts/period so the run stays short;
// all expected latencies and distances are hand-derived from the scaled parameters.
module tb_hcsr04_ranger;

  localparam int C    = 4;
  localparam int TRIG = 10;
  localparam int UPC  = 58;
  localparam int RTO  = 200;
  localparam int MAXE = 1200;
  localparam int PER  = 1500;
  localparam int GAP  = PER * C + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hcsr04_ranger_if bus ();

  hcsr04_ranger #(
    .CYC_PER_US      (C),
    .TRIG_US         (TRIG),
    .US_PER_CM       (UPC),
    .RISE_TIMEOUT_US (RTO),
    .MAX_ECHO_US     (MAXE),
    .PERIOD_US       (PER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #950000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_trig(input string tag, input int limit, output int n);
    n = 0;
    while (bus.trig !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    chk({tag, "_trig_seen"}, bus.trig, 1);
  endtask

  task automatic wait_valid(input string tag, input int limit, output int n);
    n = 0;
    while (bus.valid !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    chk({tag, "_valid_seen"}, bus.valid, 1);
  endtask

  task automatic trig_phase(input string tag, input int exp_gap);
    int n;
    wait_trig(tag, GAP + 9000, n);
    if (exp_gap > 0) chk({tag, "_gap"}, cyc - t_prev, exp_gap);
    t_prev = cyc;
    n = 0;
    while (bus.trig === 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    chk({tag, "_trig_w"}, n, TRIG * C);
  endtask

  task automatic echo_phase(input string tag, input int dly, input int w, input logic [15:0] ed);
    int n;
    step(dly * C);
    bus.echo = 1'b1;
    step(w * C);
    bus.echo = 1'b0;
    wait_valid(tag, 20, n);
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_dist"}, bus.distance, ed);
    chk({tag, "_to"}, bus.timeout, 0);
    step(1);
    chk({tag, "_valid_1cyc"}, bus.valid, 0);
  endtask

  initial begin
    int n;
    int seen;
    int t_fall;
    bus.enable = 1'b0;
    bus.echo   = 1'b0;
    rst        = 1'b1;
    step(3);
    chk("rst_trig", bus.trig, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_distance", bus.distance, 0);
    chk("rst_busy", bus.busy, 0);

    rst        = 1'b0;
    bus.enable = 1'b1;

    // 580 us echo after 100 us -> 10 cm
    trig_phase("t1", 0);
    echo_phase("t1", 100, 580, 16'd10);

    // floor conversion edges
    trig_phase("t2a", GAP);
    echo_phase("t2a", 20, 57, 16'd0);
    trig_phase("t2b", GAP);
    echo_phase("t2b", 20, 58, 16'd1);
    trig_phase("t2c", GAP);
    echo_phase("t2c", 20, 1159, 16'd19);

    // no echo: timeout exactly RTO us after trig falls
    trig_phase("t3", GAP);
    wait_valid("t3", RTO * C + 10, n);
    chk("t3_lat", n, RTO * C);
    chk("t3_dist", bus.distance, 16'hFFFF);
    chk("t3_to", bus.timeout, 1);
    step(1);
    chk("t3_valid_1cyc", bus.valid, 0);

    // long echo: timeout at MAXE us of high time, next trig waits for echo low
    trig_phase("t4", GAP);
    step(20 * C);
    bus.echo = 1'b1;
    wait_valid("t4", MAXE * C + 20, n);
    chk("t4_lat", n, MAXE * C + 3);
    chk("t4_dist", bus.distance, 16'hFFFF);
    chk("t4_to", bus.timeout, 1);
    seen = 0;
    for (int i = 0; i < 1700 * C - n; i++) begin
      step(1);
      if (bus.trig === 1'b1) seen = 1;
    end
    chk("t4_no_early_trig", seen, 0);
    bus.echo = 1'b0;
    t_fall   = cyc;
    trig_phase("t4n", 0);
    chk("t4_fall_to_trig", t_prev - t_fall, 4);
    echo_phase("t4n", 20, 100, 16'd1);

    // continuous enable, then drop enable mid-measure
    trig_phase("t5a", GAP);
    echo_phase("t5a", 20, 100, 16'd1);
    trig_phase("t5b", GAP);
    echo_phase("t5b", 20, 100, 16'd1);
    trig_phase("t5c", GAP);
    step(20 * C);
    bus.echo = 1'b1;
    step(50 * C);
    bus.enable = 1'b0;
    step(50 * C);
    bus.echo = 1'b0;
    wait_valid("t5c", 20, n);
    chk("t5c_dist", bus.distance, 16'd1);
    seen = 0;
    for (int i = 0; i < GAP + 200; i++) begin
      step(1);
      if (bus.trig === 1'b1) seen = 1;
    end
    chk("t5_no_trig_after_disable", seen, 0);
    chk("t5_idle_busy", bus.busy, 0);

    // reset during MEASURE
    bus.enable = 1'b1;
    trig_phase("t6", 0);
    step(20 * C);
    bus.echo = 1'b1;
    step(50 * C);
    chk("t6_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_trig", bus.trig, 0);
    chk("t6_rst_valid", bus.valid, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_distance", bus.distance, 0);
    bus.echo = 1'b0;
    step(2);
    rst = 1'b0;
    wait_trig("t6_restart", 2, n);
    chk("t6_restart_within2", (n <= 2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
